// File: rtl/ibex_xif_compressed_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ibex_xif_compressed_requester                                   |
// | Purpose  : Takes 16-bit parcels from fetch and asks a coprocessor over the |
// |            X-interface compressed channel to expand them. It returns the   |
// |            32-bit result (or an illegal marker) to decode.                 |
// | Ports    : clk_i/rst_ni                 clock, async active-low reset      |
// |            instr_valid_i/instr_i/mode_i fetch parcel in                    |
// |            instr_ready_o                parcel accepted this cycle         |
// |            flush_i                      discard in-flight work             |
// |            x_compressed_valid_o/ready_i coprocessor handshake              |
// |            x_compressed_req_o           {instr[15:0], mode[1:0], id}       |
// |            x_compressed_resp_i          {instr[31:0], accept}              |
// |            out_valid_o/out_ready_i      result handshake to decode         |
// |            out_instr_o/out_illegal_o    expanded instruction / illegal     |
// |            timeout_o                    one-cycle pulse on timeout abort   |
// | Config   : define IBEX_XIF_COMP_TIMEOUT_EN to enable the REQ timeout.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ibex_xif_compressed_requester #(
   parameter int unsigned TimeoutCycles = 16,
   parameter int unsigned X_ID_WIDTH    = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   instr_valid_i,
   input  logic [15:0]            instr_i,
   input  logic [1:0]             mode_i,
   output logic                   instr_ready_o,
   input  logic                   flush_i,
   output logic                   x_compressed_valid_o,
   input  logic                   x_compressed_ready_i,
   output logic [X_ID_WIDTH+17:0] x_compressed_req_o,
   input  logic [32:0]            x_compressed_resp_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [31:0]            out_instr_o,
   output logic                   out_illegal_o,
   output logic                   timeout_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Elaboration-time range check on the timeout length.
   if ((TimeoutCycles < 2) || (TimeoutCycles > 255)) begin : g_bad_timeout
      $error("TimeoutCycles must lie in 2..255");
   end

   state_e                r_state;
   logic [X_ID_WIDTH-1:0] r_id;
   logic [15:0]           r_req_instr;
   logic [1:0]            r_req_mode;
   logic [X_ID_WIDTH-1:0] r_req_id;
   logic                  r_flush_pending;
   logic                  r_x_valid;
   logic                  r_out_valid;
   logic [31:0]           r_out_instr;
   logic                  r_out_illegal;
   logic                  r_timeout;

   logic                  w_handshake;
   logic                  w_is_compressed;
   logic [X_ID_WIDTH-1:0] w_next_id;
   logic                  w_timeout_hit;
   logic                  w_discard;
   logic                  w_resp_accept;
   logic [31:0]           w_resp_instr;

   assign w_resp_accept = x_compressed_resp_i[0];
   assign w_resp_instr  = x_compressed_resp_i[32:1];

   // A flush always blocks a new parcel, even when the FSM could take one.
   assign instr_ready_o   = !flush_i &&
                            ((r_state == IDLE) || ((r_state == DONE) && out_ready_i));
   assign w_handshake     = instr_valid_i && instr_ready_o;
   assign w_is_compressed = (instr_i[1:0] != 2'b11);
   // A parcel taken in DONE is tagged with the id that follows the one consumed.
   assign w_next_id       = (r_state == DONE) ? (r_id + 1'b1) : r_id;
   // A flush seen in the very cycle the request completes also discards it.
   assign w_discard       = r_flush_pending || flush_i;

`ifdef IBEX_XIF_COMP_TIMEOUT_EN
   localparam logic [7:0] c_cnt_last = 8'(TimeoutCycles - 1);
   logic [7:0] r_cnt;

   // Counter is held at zero outside REQ, so every REQ entry starts from zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= 8'd0;
      end else if ((r_state != REQ) || x_compressed_ready_i) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign w_timeout_hit = (r_cnt == c_cnt_last);
`else
   assign w_timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state         <= IDLE;
         r_id            <= '0;
         r_req_instr     <= 16'h0;
         r_req_mode      <= 2'b00;
         r_req_id        <= '0;
         r_flush_pending <= 1'b0;
         r_x_valid       <= 1'b0;
         r_out_valid     <= 1'b0;
         r_out_instr     <= 32'h0;
         r_out_illegal   <= 1'b0;
         r_timeout       <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               // Only a parcel handshake leaves IDLE; handled below.
            end
            REQ: begin
               if (flush_i) begin
                  r_flush_pending <= 1'b1;
               end
               // Ready has priority over the timeout in the same cycle.
               if (x_compressed_ready_i || w_timeout_hit) begin
                  r_x_valid       <= 1'b0;
                  r_flush_pending <= 1'b0;
                  r_timeout       <= !x_compressed_ready_i;
                  if (w_discard) begin
                     r_state <= IDLE;
                     r_id    <= r_id + 1'b1;
                  end else begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                     if (x_compressed_ready_i && w_resp_accept) begin
                        r_out_instr   <= w_resp_instr;
                        r_out_illegal <= 1'b0;
                     end else begin
                        r_out_instr   <= 32'h0;
                        r_out_illegal <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if (flush_i) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end else if (out_ready_i) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_id        <= r_id + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         // New parcel: overrides the IDLE fallthrough of a DONE consume,
         // giving back-to-back operation without a bubble.
         if (w_handshake) begin
            if (w_is_compressed) begin
               r_state     <= REQ;
               r_x_valid   <= 1'b1;
               r_req_instr <= instr_i;
               r_req_mode  <= mode_i;
               r_req_id    <= w_next_id;
            end else begin
               r_state       <= DONE;
               r_out_valid   <= 1'b1;
               r_out_instr   <= 32'h0;
               r_out_illegal <= 1'b1;
            end
         end
      end
   end

   assign x_compressed_valid_o = r_x_valid;
   assign x_compressed_req_o   = {r_req_instr, r_req_mode, r_req_id};
   assign out_valid_o          = r_out_valid;
   assign out_instr_o          = r_out_instr;
   assign out_illegal_o        = r_out_illegal;
   assign timeout_o            = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ibex_xif_compressed_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ibex_xif_compressed_requester                                |
// | Purpose  : Directed, self-checking bench for the compressed requester.     |
// |            Expected results are queued when a parcel is driven and        |
// |            compared when the result appears on the output port.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ibex_xif_compressed_requester;

   localparam int unsigned IDW = 2;
   localparam int unsigned TO  = 4;

   logic            clk = 1'b0;
   logic            rst_ni = 1'b0;
   logic            instr_valid_i = 1'b0;
   logic [15:0]     instr_i = 16'h0;
   logic [1:0]      mode_i = 2'b00;
   logic            instr_ready_o;
   logic            flush_i = 1'b0;
   logic            x_compressed_valid_o;
   logic            x_compressed_ready_i = 1'b0;
   logic [IDW+17:0] x_compressed_req_o;
   logic [32:0]     x_compressed_resp_i = 33'h0;
   logic            out_valid_o;
   logic            out_ready_i = 1'b0;
   logic [31:0]     out_instr_o;
   logic            out_illegal_o;
   logic            timeout_o;

   int              n_checks = 0;
   int              n_err = 0;
   logic [32:0]     exp_q[$];
   logic [IDW-1:0]  exp_id = '0;

   ibex_xif_compressed_requester #(
      .TimeoutCycles(TO),
      .X_ID_WIDTH   (IDW)
   ) dut (
      .clk_i               (clk),
      .rst_ni              (rst_ni),
      .instr_valid_i       (instr_valid_i),
      .instr_i             (instr_i),
      .mode_i              (mode_i),
      .instr_ready_o       (instr_ready_o),
      .flush_i             (flush_i),
      .x_compressed_valid_o(x_compressed_valid_o),
      .x_compressed_ready_i(x_compressed_ready_i),
      .x_compressed_req_o  (x_compressed_req_o),
      .x_compressed_resp_i (x_compressed_resp_i),
      .out_valid_o         (out_valid_o),
      .out_ready_i         (out_ready_i),
      .out_instr_o         (out_instr_o),
      .out_illegal_o       (out_illegal_o),
      .timeout_o           (timeout_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_parcel(input logic [15:0] p, input logic [1:0] m);
      int n = 0;
      while (!instr_ready_o && n < 20) begin
         tick();
         n++;
      end
      if (!instr_ready_o) begin
         n_checks++;
         n_err++;
         $error("FAIL parcel_ready: observed=0 expected=1");
      end
      instr_valid_i = 1'b1;
      instr_i       = p;
      mode_i        = m;
      tick();
      instr_valid_i = 1'b0;
   endtask

   task automatic respond(input logic accept, input logic [31:0] rinstr,
                          input logic [15:0] p, input logic [1:0] m);
      chk("req_valid", 64'(x_compressed_valid_o), 64'd1);
      chk("req_fields", 64'(x_compressed_req_o), 64'({p, m, exp_id}));
      x_compressed_ready_i = 1'b1;
      x_compressed_resp_i  = {rinstr, accept};
      tick();
      x_compressed_ready_i = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      logic [32:0] e;
      while (!out_valid_o && n < 50) begin
         tick();
         n++;
      end
      if (!out_valid_o) begin
         n_checks++;
         n_err++;
         $error("FAIL %s_timeout: observed=no_out_valid expected=out_valid", tag);
      end else if (exp_q.size() == 0) begin
         n_checks++;
         n_err++;
         $error("FAIL %s_unexpected: observed=out_valid expected=none", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 64'({out_illegal_o, out_instr_o}), 64'(e));
      end
   endtask

   task automatic consume();
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      exp_id++;
   endtask

   task automatic xact(input logic [15:0] p, input logic [1:0] m, input logic accept,
                       input logic [31:0] rinstr, input string tag);
      if (p[1:0] == 2'b11) begin
         exp_q.push_back({1'b1, 32'h0});
         drive_parcel(p, m);
      end else begin
         exp_q.push_back(accept ? {1'b0, rinstr} : {1'b1, 32'h0});
         drive_parcel(p, m);
         respond(accept, rinstr, p, m);
      end
      wait_out(tag);
      consume();
   endtask

   initial begin
      int hi;
      int pulses;
      int lows;

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_x_valid", 64'(x_compressed_valid_o), 64'd0);
      chk("rst_outputs", 64'({out_illegal_o, out_instr_o, timeout_o}), 64'd0);
      chk("rst_req", 64'(x_compressed_req_o), 64'd0);
      rst_ni = 1'b1;
      tick();
      chk("idle_ready", 64'(instr_ready_o), 64'd1);

      // c.addi x1,1 accepted, result two cycles after the parcel
      exp_q.push_back({1'b0, 32'h00108093});
      drive_parcel(16'h0085, 2'b11);
      respond(1'b1, 32'h00108093, 16'h0085, 2'b11);
      chk("lat_out_valid", 64'(out_valid_o), 64'd1);
      chk("lat_x_valid_drop", 64'(x_compressed_valid_o), 64'd0);
      wait_out("caddi_result");
      consume();

      // Rejected by coprocessor, id 1
      xact(16'h4501, 2'b00, 1'b0, 32'hdeadbeef, "reject_result");

      // Non-compressed parcel: DONE next cycle, no request
      exp_q.push_back({1'b1, 32'h0});
      drive_parcel(16'h0013, 2'b00);
      chk("noncomp_x_valid", 64'(x_compressed_valid_o), 64'd0);
      chk("noncomp_out_valid", 64'(out_valid_o), 64'd1);
      wait_out("noncomp_result");
      consume();

      // Hold in DONE, then back-to-back parcel with the consume
      exp_q.push_back({1'b0, 32'h11111111});
      drive_parcel(16'h0405, 2'b01);
      respond(1'b1, 32'h11111111, 16'h0405, 2'b01);
      wait_out("hold_result");
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_stable", 64'({out_valid_o, out_illegal_o, out_instr_o}),
             64'({1'b1, 1'b0, 32'h11111111}));
      end
      out_ready_i   = 1'b1;
      instr_valid_i = 1'b1;
      instr_i       = 16'h0809;
      mode_i        = 2'b10;
      #1;
      chk("b2b_ready", 64'(instr_ready_o), 64'd1);
      tick();
      out_ready_i   = 1'b0;
      instr_valid_i = 1'b0;
      exp_id++;
      exp_q.push_back({1'b0, 32'h22222222});
      respond(1'b1, 32'h22222222, 16'h0809, 2'b10);
      wait_out("b2b_result");
      consume();

      // Flush while in REQ, ready arrives three cycles later
      drive_parcel(16'h0c0d, 2'b00);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_req_held", 64'(x_compressed_valid_o), 64'd1);
      tick();
      tick();
      x_compressed_ready_i = 1'b1;
      x_compressed_resp_i  = {32'h33333333, 1'b1};
      tick();
      x_compressed_ready_i = 1'b0;
      chk("flush_no_out", 64'(out_valid_o), 64'd0);
      chk("flush_x_drop", 64'(x_compressed_valid_o), 64'd0);
      chk("flush_idle", 64'(instr_ready_o), 64'd1);
      tick();
      chk("flush_no_out_later", 64'(out_valid_o), 64'd0);
      exp_id++;

      // Flush in DONE together with a parcel: flush wins, id unchanged
      drive_parcel(16'h0013, 2'b00);
      chk("flush_done_valid", 64'(out_valid_o), 64'd1);
      flush_i       = 1'b1;
      out_ready_i   = 1'b1;
      instr_valid_i = 1'b1;
      instr_i       = 16'h0085;
      #1;
      chk("flush_blocks_ready", 64'(instr_ready_o), 64'd0);
      tick();
      flush_i       = 1'b0;
      out_ready_i   = 1'b0;
      instr_valid_i = 1'b0;
      chk("flush_done_drop", 64'({out_valid_o, x_compressed_valid_o}), 64'd0);

`ifdef IBEX_XIF_COMP_TIMEOUT_EN
      // No ready: abort after TO cycles with a single pulse
      exp_q.push_back({1'b1, 32'h0});
      drive_parcel(16'h0085, 2'b00);
      hi     = 0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         hi     += int'(x_compressed_valid_o);
         pulses += int'(timeout_o);
         tick();
      end
      chk("timeout_valid_cycles", 64'(hi), 64'(TO));
      chk("timeout_pulses", 64'(pulses), 64'd1);
      wait_out("timeout_result");
      consume();
      // Ready on the last allowed cycle wins
      exp_q.push_back({1'b0, 32'h44444444});
      drive_parcel(16'h0101, 2'b01);
      for (int i = 0; i < int'(TO) - 1; i++) tick();
      respond(1'b1, 32'h44444444, 16'h0101, 2'b01);
      chk("late_ready_no_pulse", 64'(timeout_o), 64'd0);
      wait_out("late_ready_result");
      consume();
`else
      // Without the timeout the request waits indefinitely
      exp_q.push_back({1'b0, 32'h44444444});
      drive_parcel(16'h0101, 2'b01);
      lows   = 0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         lows   += int'(!x_compressed_valid_o);
         pulses += int'(timeout_o);
         tick();
      end
      chk("no_timeout_held", 64'(lows), 64'd0);
      chk("no_timeout_pulse", 64'(pulses), 64'd0);
      respond(1'b1, 32'h44444444, 16'h0101, 2'b01);
      wait_out("wait_result");
      consume();
`endif

      // Several more transactions; id wraps through the 2-bit range
      for (int k = 0; k < 5; k++) begin
         xact({14'(k * 37 + 5), 2'b01}, 2'(k), k[0], $urandom, "loop_result");
      end

      // Asynchronous reset mid-REQ drops the request immediately
      drive_parcel(16'h0205, 2'b00);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_rst_x_valid", 64'(x_compressed_valid_o), 64'd0);
      chk("async_rst_req", 64'(x_compressed_req_o), 64'd0);
      tick();
      rst_ni = 1'b1;
      exp_id = '0;
      exp_q.delete();
      tick();
      xact(16'h0085, 2'b11, 1'b1, 32'h00108093, "post_rst_result");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
